// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared definitions for the stopwatch core.
//   state_t      - control states (IDLE, RUN, PAUSE)
//   *_MAX        - highest legal value of each BCD digit position
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // count is zero, stopped
    RUN   = 2'd1,  // counting on every tick
    PAUSE = 2'd2   // count held, stopped
  } state_t;

  localparam int ONES_MAX     = 9;
  localparam int SEC_TENS_MAX = 5;
  localparam int MIN_TENS_MAX = 5;

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// bcd_digit: one decimal digit of the stopwatch count, wrapping at MAX.
//   clock_in   - system clock
//   reset_n_in - asynchronous active-low reset, digit goes to 0
//   clear      - synchronous clear to 0, overrides inc
//   inc        - advance the digit by one this cycle
//   value      - current digit value, always 0..MAX
//   carry      - inc while at MAX; the next digit up advances with it
module bcd_digit #(
  parameter int MAX = 9
) (
  input  logic       clock_in,
  input  logic       reset_n_in,
  input  logic       clear,
  input  logic       inc,
  output logic [3:0] value,
  output logic       carry
);

  localparam logic [3:0] MAX_V = 4'(MAX);

  assign carry = inc & (value == MAX_V);

  // NOTE: state registers use non-blocking assignments so every flop in the
  // design samples its inputs from before the edge, regardless of block order.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (inc) begin
      value <= (value == MAX_V) ? 4'd0 : value + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: MM:SS stopwatch counting rising edges of a 1 Hz tick.
//   clock_in      - 100 MHz system clock
//   reset_n_in    - asynchronous active-low reset
//   tick_in       - 1 Hz square wave, synchronous to clock_in
//   start_stop_in - async button level; each rising edge toggles run/pause
//   clear_in      - async button level; each rising edge clears the count
//   sec_ones_out, sec_tens_out, min_ones_out, min_tens_out - BCD digits
//   running_out   - high while in RUN
//   wrap_out      - one-cycle pulse on the 59:59 -> 00:00 advance
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock_in,
  input  logic       reset_n_in,
  input  logic       tick_in,
  input  logic       start_stop_in,
  input  logic       clear_in,
  output logic [3:0] sec_ones_out,
  output logic [3:0] sec_tens_out,
  output logic [3:0] min_ones_out,
  output logic [3:0] min_tens_out,
  output logic       running_out,
  output logic       wrap_out
);

  // Button synchronizers, edge detectors and tick edge detector.
  logic [SYNC_STAGES-1:0] start_sync;
  logic [SYNC_STAGES-1:0] clear_sync;
  logic [SYNC_STAGES-1:0] prime_sr;
  logic start_prev, clear_prev;
  logic start_armed, clear_armed;
  logic tick_q;

  logic start_lvl, clear_lvl, primed;
  logic start_p, clear_p, tick_p;

  assign start_lvl = start_sync[SYNC_STAGES-1];
  assign clear_lvl = clear_sync[SYNC_STAGES-1];

  // primed goes high once the synchronizers hold real post-reset samples
  // rather than their reset zeros.
  assign primed = prime_sr[SYNC_STAGES-1];

  // A button only produces edges after it has been seen low since reset, so
  // a button held through reset release does not fire.
  assign start_p = start_lvl & ~start_prev & start_armed;
  assign clear_p = clear_lvl & ~clear_prev & clear_armed;
  assign tick_p  = tick_in & ~tick_q;

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      start_sync  <= '0;
      clear_sync  <= '0;
      prime_sr    <= '0;
      start_prev  <= 1'b0;
      clear_prev  <= 1'b0;
      start_armed <= 1'b0;
      clear_armed <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      start_sync  <= {start_sync[SYNC_STAGES-2:0], start_stop_in};
      clear_sync  <= {clear_sync[SYNC_STAGES-2:0], clear_in};
      prime_sr    <= {prime_sr[SYNC_STAGES-2:0], 1'b1};
      start_prev  <= start_lvl;
      clear_prev  <= clear_lvl;
      start_armed <= start_armed | (primed & ~start_lvl);
      clear_armed <= clear_armed | (primed & ~clear_lvl);
      tick_q      <= tick_in;
    end
  end

  // Control state machine.
  state_t state;
  logic   advance;
  logic   so_carry, st_carry, mo_carry, mt_carry;

  // Clear overrides a coincident tick; a start coinciding with a tick only
  // lets the tick count when the state was already RUN.
  assign advance = tick_p & (state == RUN) & ~clear_p;

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state       <= IDLE;
      running_out <= 1'b0;
      wrap_out    <= 1'b0;
    end else begin
      wrap_out <= mt_carry;
      if (clear_p) begin
        state       <= IDLE;
        running_out <= 1'b0;
      end else if (start_p) begin
        case (state)
          RUN: begin
            state       <= PAUSE;
            running_out <= 1'b0;
          end
          IDLE, PAUSE: begin
            state       <= RUN;
            running_out <= 1'b1;
          end
          default: begin
            state       <= IDLE;
            running_out <= 1'b0;
          end
        endcase
      end
    end
  end

  // Digit chain: every digit that changes in one advance does so at the
  // same edge because the carries are combinational.
  bcd_digit #(.MAX(ONES_MAX)) u_sec_ones (
    .clock_in  (clock_in),
    .reset_n_in(reset_n_in),
    .clear     (clear_p),
    .inc       (advance),
    .value     (sec_ones_out),
    .carry     (so_carry)
  );

  bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clock_in  (clock_in),
    .reset_n_in(reset_n_in),
    .clear     (clear_p),
    .inc       (advance & so_carry),
    .value     (sec_tens_out),
    .carry     (st_carry)
  );

  bcd_digit #(.MAX(ONES_MAX)) u_min_ones (
    .clock_in  (clock_in),
    .reset_n_in(reset_n_in),
    .clear     (clear_p),
    .inc       (advance & st_carry),
    .value     (min_ones_out),
    .carry     (mo_carry)
  );

  bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .clock_in  (clock_in),
    .reset_n_in(reset_n_in),
    .clear     (clear_p),
    .inc       (advance & mo_carry),
    .value     (min_tens_out),
    .carry     (mt_carry)
  );

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: self-checking bench for stopwatch_core. A reference
// model tracks the count as plain seconds (0..3599) and the run state, and
// is compared against the DUT on every falling clock edge.
module tb_stopwatch_core;

  localparam int SYNC = 2;
  localparam int BTN_LAT = SYNC + 1;  // edges from button drive to effect

  logic       clock_in = 1'b0;
  logic       reset_n_in = 1'b0;
  logic       tick_in = 1'b0;
  logic       start_stop_in = 1'b0;
  logic       clear_in = 1'b0;
  logic [3:0] sec_ones_out, sec_tens_out, min_ones_out, min_tens_out;
  logic       running_out, wrap_out;

  stopwatch_core #(.SYNC_STAGES(SYNC)) dut (
    .clock_in     (clock_in),
    .reset_n_in   (reset_n_in),
    .tick_in      (tick_in),
    .start_stop_in(start_stop_in),
    .clear_in     (clear_in),
    .sec_ones_out (sec_ones_out),
    .sec_tens_out (sec_tens_out),
    .min_ones_out (min_ones_out),
    .min_tens_out (min_tens_out),
    .running_out  (running_out),
    .wrap_out     (wrap_out)
  );

  always #5 clock_in = ~clock_in;

  logic [15:0] dut_bcd;
  assign dut_bcd = {min_tens_out, min_ones_out, sec_tens_out, sec_ones_out};

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model.
  typedef enum {M_IDLE, M_RUN, M_PAUSE} m_state_t;
  m_state_t m_state = M_IDLE;
  int m_count = 0;
  bit m_wrap = 1'b0;
  int cyc = 0;
  int start_due[$];
  int clear_due[$];
  int tick_due[$];
  bit start_lvl = 1'b0, clear_lvl = 1'b0, tick_lvl = 1'b0;
  bit arm_start = 1'b0, arm_clear = 1'b0;

  function automatic logic [15:0] to_bcd(input int c);
    int s, m;
    s = c % 60;
    m = c / 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_step();
    bit st, cl, tk;
    if (!reset_n_in) begin
      m_state = M_IDLE;
      m_count = 0;
      m_wrap  = 1'b0;
      start_due.delete();
      clear_due.delete();
      tick_due.delete();
      arm_start = !start_lvl;
      arm_clear = !clear_lvl;
    end else begin
      cyc++;
      st = (start_due.size() > 0 && start_due[0] == cyc);
      cl = (clear_due.size() > 0 && clear_due[0] == cyc);
      tk = (tick_due.size() > 0 && tick_due[0] == cyc);
      if (st) void'(start_due.pop_front());
      if (cl) void'(clear_due.pop_front());
      if (tk) void'(tick_due.pop_front());
      m_wrap = 1'b0;
      if (cl) begin
        m_state = M_IDLE;
        m_count = 0;
      end else begin
        if (tk && m_state == M_RUN) begin
          m_wrap  = (m_count == 3599);
          m_count = (m_count + 1) % 3600;
        end
        if (st) m_state = (m_state == M_RUN) ? M_PAUSE : M_RUN;
      end
    end
  endtask

  initial forever begin
    @(posedge clock_in or negedge reset_n_in);
    model_step();
  end

  // Per-cycle comparison and wrap pulse counter.
  int wrap_cnt = 0;
  initial forever begin
    @(negedge clock_in);
    if (reset_n_in) begin
      check("cyc_digits", 32'(dut_bcd), 32'(to_bcd(m_count)));
      check("cyc_running", 32'(running_out), 32'(m_state == M_RUN));
      check("cyc_wrap", 32'(wrap_out), 32'(m_wrap));
      if (wrap_out) wrap_cnt++;
    end
  end

  // Stimulus helpers; all drive #1 after a rising edge.
  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic set_tick(input bit v);
    if (v && !tick_lvl && reset_n_in) tick_due.push_back(cyc + 1);
    tick_lvl = v;
    tick_in  = v;
  endtask

  task automatic set_btn(input int sel, input bit v);
    if (sel == 0) begin
      if (v && !start_lvl && arm_start && reset_n_in) start_due.push_back(cyc + BTN_LAT);
      if (!v && reset_n_in) arm_start = 1'b1;
      if (v && !reset_n_in) arm_start = 1'b0;
      start_lvl     = v;
      start_stop_in = v;
    end else begin
      if (v && !clear_lvl && arm_clear && reset_n_in) clear_due.push_back(cyc + BTN_LAT);
      if (!v && reset_n_in) arm_clear = 1'b1;
      if (v && !reset_n_in) arm_clear = 1'b0;
      clear_lvl = v;
      clear_in  = v;
    end
  endtask

  task automatic tick_pulse();
    set_tick(1'b1);
    step();
    set_tick(1'b0);
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_pulse();
  endtask

  // Press a button; with coincide set, a tick edge lands on the same cycle
  // as the button's edge pulse inside the DUT.
  task automatic press(input int sel, input bit coincide);
    set_btn(sel, 1'b1);
    step();
    step();
    if (coincide) set_tick(1'b1);
    step();
    set_tick(1'b0);
    set_btn(sel, 1'b0);
    repeat (4) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    // Reset with tick high; no count may come from the held tick.
    tick_in  = 1'b1;
    tick_lvl = 1'b1;
    #23;
    check("rst_digits", 32'(dut_bcd), 32'h0000);
    check("rst_running", 32'(running_out), 32'h0);
    check("rst_wrap", 32'(wrap_out), 32'h0);
    step();
    reset_n_in = 1'b1;
    repeat (6) step();
    press(0, 1'b0);
    check("held_tick_no_count", 32'(dut_bcd), 32'h0000);
    check("held_tick_running", 32'(running_out), 32'h1);
    set_tick(1'b0);
    step();

    // Start then three ticks.
    ticks(3);
    check("three_ticks", 32'(dut_bcd), 32'h0003);
    check("three_ticks_running", 32'(running_out), 32'h1);

    // Carries and full wrap.
    press(1, 1'b0);
    check("clear_digits", 32'(dut_bcd), 32'h0000);
    check("clear_running", 32'(running_out), 32'h0);
    press(0, 1'b0);
    ticks(59);
    check("preload_0059", 32'(dut_bcd), 32'h0059);
    ticks(1);
    check("carry_0100", 32'(dut_bcd), 32'h0100);
    ticks(3599 - 60);
    check("preload_5959", 32'(dut_bcd), 32'h5959);
    wrap_cnt = 0;
    ticks(1);
    repeat (3) step();
    check("wrap_digits", 32'(dut_bcd), 32'h0000);
    check("wrap_pulse_count", 32'(wrap_cnt), 32'd1);
    check("wrap_running", 32'(running_out), 32'h1);

    // Pause holds the count, resume continues.
    press(1, 1'b0);
    press(0, 1'b0);
    ticks(5);
    check("run_0005", 32'(dut_bcd), 32'h0005);
    press(0, 1'b0);
    ticks(4);
    check("pause_hold", 32'(dut_bcd), 32'h0005);
    check("pause_running", 32'(running_out), 32'h0);
    press(0, 1'b0);
    ticks(1);
    check("resume_0006", 32'(dut_bcd), 32'h0006);
    check("resume_running", 32'(running_out), 32'h1);

    // Clear coinciding with a tick at 12:34.
    press(1, 1'b0);
    press(0, 1'b0);
    ticks(754);
    check("preload_1234", 32'(dut_bcd), 32'h1234);
    press(1, 1'b1);
    check("clr_tick_digits", 32'(dut_bcd), 32'h0000);
    check("clr_tick_running", 32'(running_out), 32'h0);

    // Start coinciding with a tick in RUN: counts, then pauses.
    press(0, 1'b0);
    ticks(2);
    press(0, 1'b1);
    check("start_tick_run", 32'(dut_bcd), 32'h0003);
    check("start_tick_paused", 32'(running_out), 32'h0);
    // Start coinciding with a tick in PAUSE: no count, runs.
    press(0, 1'b1);
    check("start_tick_pause", 32'(dut_bcd), 32'h0003);
    check("start_tick_resumed", 32'(running_out), 32'h1);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      if (r < 65)      tick_pulse();
      else if (r < 80) press(0, $urandom_range(0, 2) == 0);
      else if (r < 86) press(1, $urandom_range(0, 2) == 0);
      else             repeat ($urandom_range(1, 4)) step();
    end

    // Asynchronous reset mid-count with start held across release.
    press(1, 1'b0);
    press(0, 1'b0);
    ticks(462);
    check("preload_0742", 32'(dut_bcd), 32'h0742);
    #2;
    reset_n_in = 1'b0;
    #1;
    check("async_rst_digits", 32'(dut_bcd), 32'h0000);
    check("async_rst_running", 32'(running_out), 32'h0);
    check("async_rst_wrap", 32'(wrap_out), 32'h0);
    set_btn(0, 1'b1);
    step();
    step();
    reset_n_in = 1'b1;
    repeat (10) step();
    check("held_start_idle", 32'(running_out), 32'h0);
    check("held_start_digits", 32'(dut_bcd), 32'h0000);
    set_btn(0, 1'b0);
    repeat (5) step();
    press(0, 1'b0);
    check("start_after_release", 32'(running_out), 32'h1);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
